// File: rtl/multiword_add_pkg.sv
// Shared types and constants for the multi-word add/subtract sequencer.
package multiword_add_pkg;

    localparam int unsigned WORD_W        = 32;
    localparam int unsigned MAX_WORDS_DEF = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        FIN   = 2'd3
    } state_e;

    // Bitwise incrementer for small counters, so the shared CLA stays the only adder.
    function automatic logic [31:0] incr32(input logic [31:0] x);
        logic [31:0] r;
        logic        c;
        c = 1'b1;
        for (int i = 0; i < 32; i++) begin
            r[i] = x[i] ^ c;
            c    = x[i] & c;
        end
        return r;
    endfunction

endpackage

// File: rtl/CLA_32bit.sv
// 32-bit carry-lookahead adder: eight 4-bit groups with a group-level carry chain.
module CLA_32bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);

    localparam int unsigned GRP_W = 4;
    localparam int unsigned N_GRP = 8;

    logic [31:0]      p;
    logic [31:0]      g;
    logic [31:0]      c;
    logic [N_GRP-1:0] gg;
    logic [N_GRP-1:0] gp;
    logic [N_GRP:0]   gc;

    always_comb begin
        p  = a ^ b;
        g  = a & b;
        c  = '0;
        gg = '0;
        gp = '0;
        gc = '0;
        // group generate/propagate
        for (int k = 0; k < N_GRP; k++) begin
            gp[k] = &p[GRP_W*k +: GRP_W];
            for (int j = 0; j < GRP_W; j++) begin
                gg[k] = g[GRP_W*k + j] | (p[GRP_W*k + j] & gg[k]);
            end
        end
        gc[0] = cin;
        for (int k = 0; k < N_GRP; k++) begin
            gc[k+1] = gg[k] | (gp[k] & gc[k]);
        end
        // bit carries inside each group from that group's carry-in
        for (int k = 0; k < N_GRP; k++) begin
            c[GRP_W*k] = gc[k];
            for (int j = 0; j < GRP_W - 1; j++) begin
                c[GRP_W*k + j + 1] = g[GRP_W*k + j] | (p[GRP_W*k + j] & c[GRP_W*k + j]);
            end
        end
        sum  = p ^ c;
        cout = gc[N_GRP];
    end

endmodule

// File: rtl/multiword_add_seq.sv
// Multi-precision add/subtract: streams 32-bit word pairs LSW first through one CLA,
// chaining the carry, and reports final carry, signed overflow and zero.
module multiword_add_seq
    import multiword_add_pkg::*;
#(
    parameter int unsigned MAX_WORDS = MAX_WORDS_DEF,
    parameter int unsigned CNT_W     = $clog2(MAX_WORDS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [CNT_W-1:0]  cmd_nwords,
    input  logic              cmd_sub,
    input  logic              cmd_cin,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_a,
    input  logic [WORD_W-1:0] in_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_sum,
    output logic              out_last,
    output logic              done,
    output logic              done_cout,
    output logic              done_ovf,
    output logic              done_zero
);

    state_e             state;
    state_e             state_nx;
    logic [CNT_W-1:0]   nwords_q;
    logic [CNT_W-1:0]   nwords_clamp;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_inc;
    logic               sub_q;
    logic               carry;
    logic               zero_acc;
    logic               ovf_reg;
    logic [WORD_W-1:0]  b_eff;
    logic [WORD_W-1:0]  sum;
    logic               cout;
    logic               accept;
    logic               cmd_fire;
    logic               last_word;
    logic               fin_from_idle;
    logic               fin_from_flush;

    assign nwords_clamp = (cmd_nwords > CNT_W'(MAX_WORDS)) ? CNT_W'(MAX_WORDS) : cmd_nwords;
    assign cnt_inc      = CNT_W'(incr32(32'(cnt)));
    assign last_word    = (cnt_inc == nwords_q);
    assign b_eff        = sub_q ? ~in_b : in_b;
    assign accept       = in_valid & in_ready;
    assign cmd_fire     = cmd_valid & cmd_ready;

    CLA_32bit u_cla (
        .a    (in_a),
        .b    (b_eff),
        .cin  (carry),
        .sum  (sum),
        .cout (cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state and handshake decode.
    always_comb begin
        state_nx       = state;
        cmd_ready      = 1'b0;
        in_ready       = 1'b0;
        fin_from_idle  = 1'b0;
        fin_from_flush = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    if (nwords_clamp == '0) begin
                        state_nx      = FIN;
                        fin_from_idle = 1'b1;
                    end else begin
                        state_nx = RUN;
                    end
                end
            end
            RUN: begin
                in_ready = !out_valid || out_ready;
                if (in_valid && in_ready && last_word) begin
                    state_nx = FLUSH;
                end
            end
            FLUSH: begin
                if (out_valid && out_ready && out_last) begin
                    state_nx       = FIN;
                    fin_from_flush = 1'b1;
                end
            end
            FIN: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Datapath: operation context, carry chain, result register and completion flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            nwords_q  <= '0;
            sub_q     <= 1'b0;
            carry     <= 1'b0;
            zero_acc  <= 1'b0;
            ovf_reg   <= 1'b0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_last  <= 1'b0;
            done      <= 1'b0;
            done_cout <= 1'b0;
            done_ovf  <= 1'b0;
            done_zero <= 1'b0;
        end else begin
            if (cmd_fire) begin
                nwords_q <= nwords_clamp;
                sub_q    <= cmd_sub;
                carry    <= cmd_sub | cmd_cin;
                zero_acc <= 1'b1;
                ovf_reg  <= 1'b0;
                cnt      <= '0;
            end
            if (accept) begin
                out_sum   <= sum;
                out_valid <= 1'b1;
                out_last  <= last_word;
                carry     <= cout;
                zero_acc  <= zero_acc & (sum == '0);
                ovf_reg   <= (in_a[WORD_W-1] == b_eff[WORD_W-1]) & (sum[WORD_W-1] != in_a[WORD_W-1]);
                cnt       <= cnt_inc;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            done <= fin_from_idle | fin_from_flush;
            if (fin_from_idle) begin
                done_cout <= cmd_sub | cmd_cin;
                done_ovf  <= 1'b0;
                done_zero <= 1'b1;
            end else if (fin_from_flush) begin
                done_cout <= carry;
                done_ovf  <= ovf_reg;
                done_zero <= zero_acc;
            end
        end
    end

endmodule

// File: doc/multiword_add_seq.md
Name: multiword_add_seq

Overview:
Sequencer that performs N-word (multi-precision) add/subtract by streaming 32-bit word pairs, least-significant word first, through one shared CLA_32bit instance. Chains the carry between words in a register. Produces one result word per accepted input word, and at the end reports final carry, signed overflow and zero.
Sits between the ALU command path and the 32-bit CLA adder, for wide (up to MAX_WORDS×32-bit) arithmetic.

Parameters:
MAX_WORDS, 4, maximum words per operation (operand width = 32×MAX_WORDS)
CNT_W, $clog2(MAX_WORDS+1), width of word-count fields

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
cmd_valid  input  1  command offered
cmd_ready  output  1  high only in IDLE
cmd_nwords  input  CNT_W  words in operation; values >MAX_WORDS are clamped to MAX_WORDS
cmd_sub  input  1  1 = A−B (B inverted, initial carry forced to 1); 0 = A+B
cmd_cin  input  1  initial carry for add; ignored when cmd_sub=1
in_valid  input  1  operand word pair offered
in_ready  output  1  operand word accepted when in_valid&in_ready
in_a  input  32  A word
in_b  input  32  B word
out_valid  output  1  result word valid
out_ready  input  1  consumer accepts result word
out_sum  output  32  result word
out_last  output  1  marks the most-significant result word
done  output  1  one-cycle completion pulse
done_cout  output  1  final carry out (for sub: 1 = no borrow)
done_ovf  output  1  signed overflow of the top word
done_zero  output  1  all result words zero

Behaviour:
- Reset (sync, rst=1): state=IDLE; cmd_ready=1; in_ready=0; out_valid=0; out_sum=0; out_last=0; done=0; done_cout=0; done_ovf=0; done_zero=0; carry reg=0; word count=0. Reset mid-operation abandons the operation with no done pulse; the partial result is discarded.
- FSM states: IDLE, RUN, FLUSH, FIN.
- IDLE: cmd_ready=1. On cmd_valid, latch the clamped nwords and sub, and set carry=(sub?1:cin), zero_acc=1, cnt=0.
  - nwords=0 → FIN; no output words are produced. Report done_cout = initial carry, done_ovf=0, done_zero=1.
  - nwords≥1 → RUN.
- RUN: in_ready = !out_valid | out_ready. This gives full throughput of 1 word/cycle with no extra buffering.
- On each accepted word:
  - b' = sub ? ~in_b : in_b; {cout,sum} = in_a + b' + carry, computed via CLA_32bit.
  - Next cycle: out_sum=sum, out_valid=1, out_last=(cnt==nwords−1).
  - Register updates: carry←cout; zero_acc←zero_acc & (sum==0); cnt←cnt+1.
  - ovf_reg←(in_a[31]==b'[31]) & (sum[31]!=in_a[31]).
- Latency: word accepted in cycle k → out_valid in cycle k+1.
- When the last word is accepted → FLUSH, with in_ready=0.
- Output hold: out_valid stays high and out_sum/out_last stay stable until out_ready. out_valid drops after the handshake unless a new word is accepted in the same cycle, in which case the register is reloaded.
- FLUSH: waits for the handshake on the out_last word, then → FIN.
- FIN: for one cycle, done=1 with done_cout=carry, done_ovf=ovf_reg, done_zero=zero_acc; then → IDLE.
  - done_* flags hold their values until the next done pulse.
  - cmd_ready returns to 1 in the cycle after done.
- cmd_valid outside IDLE is ignored (cmd_ready=0). in_valid outside RUN is ignored.
- in_a/in_b are don't-care when in_valid=0. Inputs are sampled only on a handshake.

Decomposition:
- Package multiword_add_pkg holds:
  - state enum typedef (IDLE/RUN/FLUSH/FIN);
  - WORD_W=32 constant;
  - default MAX_WORDS.
- One sub-module: CLA_32bit, instantiated once as the sole adder. The block contains no '+' operator of its own.

Test Plan:
- Add, nwords=2, cin=0, A=0xFFFFFFFF_FFFFFFFF, B=0x00000000_00000001 → out words 0x00000000, 0x00000000 (out_last on 2nd); done_cout=1, done_zero=1, done_ovf=0.
- Sub, nwords=1, A=5, B=7 → out_sum=0xFFFFFFFE; done_cout=0 (borrow), done_ovf=0, done_zero=0.
- Add, nwords=1, A=0x7FFFFFFF, B=1 → out_sum=0x80000000; done_ovf=1, done_cout=0.
- Backpressure, nwords=4, in_valid always high, out_ready low for 3 cycles after the first result:
  - in_ready=0 and out_sum held stable during the stall;
  - all 4 words correct and in order;
  - exactly one done pulse, one cycle after the last out handshake.
- nwords=0, cmd_cin=1 → no out_valid; done pulse 1 cycle after the command; done_cout=1, done_zero=1. nwords=7 with MAX_WORDS=4 → exactly 4 words consumed.
- rst asserted after the 2nd of 4 words → next cycle all outputs at reset values, cmd_ready=1, no done. A fresh 1-word add 3+4 then yields 7.
